// File: rtl/memory_swapper_pkg.sv
// Shared definitions for the memory swapper / sorter pair: sequencer state
// encoding and default geometry and timing constants.
package memory_swapper_pkg;

   localparam int N_DEF           = 7;
   localparam int BITS_DEF        = 8;
   localparam int RD_LAT_DEF      = 1;
   localparam int SWAP_CYCLES_DEF = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ_A,
      S_READ_B,
      S_CMP,
      S_SWAP,
      S_GAP,
      S_DONE
   } state_t;

endpackage

// File: rtl/memory_sorter.sv
// Bubble-sort sequencer for memory_swapper. It reads adjacent pairs through
// the swapper's read port and issues swap commands for out-of-order pairs.
// A pass that makes no swap ends the sort early.
module memory_sorter
   import memory_swapper_pkg::*;
#(
   parameter int N           = N_DEF,
   parameter int BITS        = BITS_DEF,
   parameter int RD_LAT      = RD_LAT_DEF,
   parameter int SWAP_CYCLES = SWAP_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   input  logic [N:0]      count,
   input  logic [BITS-1:0] data_r,
   output logic [N-1:0]    address_r,
   output logic [N-1:0]    address_A,
   output logic [N-1:0]    address_B,
   output logic            swap,
   output logic            busy,
   output logic            done,
   output logic [2*N-1:0]  swap_count
);

   // One counter serves both the read-wait and the swap-hold intervals.
   localparam int CNT_MAX = (RD_LAT > SWAP_CYCLES) ? RD_LAT : SWAP_CYCLES;
   localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_LAT);
   localparam logic [CNT_W-1:0] SW_LAST = CNT_W'(SWAP_CYCLES - 1);
   localparam logic [N:0]       LEN_MAX = {1'b1, {N{1'b0}}};

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [N-1:0]     j_reg;
   logic [N-1:0]     limit_reg;
   logic             swapped_reg;
   logic [BITS-1:0]  a_reg;
   logic [BITS-1:0]  b_reg;

   logic [N:0]       len_next;
   logic [N-1:0]     limit_next;
   logic [N:0]       j_inc;
   logic             a_gt_b;
   logic             step;
   logic             more_in_pass;
   logic             sort_finished;

   // Length clamping, pair comparison and end-of-pass decisions.
   always_comb begin
      len_next      = (count > LEN_MAX) ? LEN_MAX : count;
      // For len = 2^N the low bits are zero and the wrap yields 2^N-1.
      limit_next    = len_next[N-1:0] - N'(1);
      j_inc         = {1'b0, j_reg} + (N+1)'(1);
      a_gt_b        = (a_reg > b_reg);
      step          = ((state_reg == S_CMP) && !a_gt_b) || (state_reg == S_GAP);
      more_in_pass  = (j_inc < {1'b0, limit_reg});
      sort_finished = !swapped_reg || (limit_reg == N'(1));
   end

   // Sequencer: state, counters, captured operands and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= '0;
         j_reg       <= '0;
         limit_reg   <= '0;
         swapped_reg <= 1'b0;
         a_reg       <= '0;
         b_reg       <= '0;
         address_r   <= '0;
         address_A   <= '0;
         address_B   <= '0;
         swap        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         swap_count  <= '0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  j_reg       <= '0;
                  limit_reg   <= limit_next;
                  swapped_reg <= 1'b0;
                  swap_count  <= '0;
                  busy        <= 1'b1;
                  address_r   <= '0;
                  cnt_reg     <= '0;
                  state_reg   <= (len_next <= (N+1)'(1)) ? S_DONE : S_READ_A;
               end
            end
            S_READ_A: begin
               if (cnt_reg == RD_LAST) begin
                  a_reg     <= data_r;
                  address_r <= j_inc[N-1:0];
                  cnt_reg   <= '0;
                  state_reg <= S_READ_B;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            S_READ_B: begin
               if (cnt_reg == RD_LAST) begin
                  b_reg     <= data_r;
                  cnt_reg   <= '0;
                  state_reg <= S_CMP;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            S_CMP: begin
               // Equal values stay put, keeping the sort stable.
               if (a_gt_b) begin
                  address_A   <= j_reg;
                  address_B   <= j_inc[N-1:0];
                  swap        <= 1'b1;
                  swapped_reg <= 1'b1;
                  swap_count  <= swap_count + (2*N)'(1);
                  cnt_reg     <= '0;
                  state_reg   <= S_SWAP;
               end
            end
            S_SWAP: begin
               if (cnt_reg == SW_LAST) begin
                  swap      <= 1'b0;
                  cnt_reg   <= '0;
                  state_reg <= S_GAP;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            S_GAP: begin
               // Addresses hold for one idle cycle; the next step follows below.
            end
            S_DONE: begin
               done      <= 1'b1;
               busy      <= 1'b0;
               address_r <= '0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase

         // Advance to the next pair, start a shorter pass, or finish.
         if (step) begin
            if (more_in_pass) begin
               j_reg     <= j_inc[N-1:0];
               address_r <= j_inc[N-1:0];
               state_reg <= S_READ_A;
            end else if (sort_finished) begin
               state_reg <= S_DONE;
            end else begin
               limit_reg   <= limit_reg - N'(1);
               j_reg       <= '0;
               swapped_reg <= 1'b0;
               address_r   <= '0;
               state_reg   <= S_READ_A;
            end
         end
      end
   end

endmodule
